// File: rtl/riscpu_trace_pkg.sv
// Shared trace types: default result width, timestamp width and entry layout.
// Latency: n/a (types only).
// Backpressure: n/a.
package riscpu_trace_pkg;

    localparam int TRACE_DATA_W = 16;
    localparam int TRACE_TS_W   = 16;

    // Entry layout at the default result width; timestamp sits above the data.
    typedef struct packed {
        logic [TRACE_TS_W-1:0]   ts;
        logic [TRACE_DATA_W-1:0] data;
    } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// Circular trace storage with read/write pointers and occupancy count.
// Latency: push visible on count/rdata the cycle after the write edge.
// Backpressure: none internally; caller must only push when not full or popping.
module trace_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset && !flush) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/result_trace_buffer.sv
// Captures changes on the CPU result bus into a show-ahead trace buffer (TRACE_TIMESTAMP_EN adds rd_ts).
// Latency: a capture is visible on rd_valid/count one cycle after it is detected.
// Backpressure: rd_valid/rd_ready pops; captures arriving when full with no pop are dropped and flag overflow.
module result_trace_buffer
    import riscpu_trace_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = TRACE_DATA_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_W-1:0]      result_i,
    input  logic                   capture_en,
    input  logic                   clear,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [DATA_W-1:0]      rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
`ifdef TRACE_TIMESTAMP_EN
    ,
    output logic [TRACE_TS_W-1:0]  rd_ts
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef TRACE_TIMESTAMP_EN
    localparam int ENTRY_W = DATA_W + TRACE_TS_W;
`else
    localparam int ENTRY_W = DATA_W;
`endif

    logic               full;
    logic               pop;
    logic               cap_req;
    logic               push;
    logic               armed;
    logic [DATA_W-1:0]  last_val;
    logic [ENTRY_W-1:0] fifo_wdata;
    logic [ENTRY_W-1:0] fifo_rdata;

    assign rd_valid = (count != '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign pop      = rd_valid && rd_ready && !clear;
    // An un-armed tracker captures whatever value is present.
    assign cap_req  = capture_en && (!armed || (result_i != last_val));
    assign push     = cap_req && !clear && (!full || pop);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            armed    <= 1'b0;
            last_val <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                armed    <= 1'b1;
                last_val <= result_i;
            end
            if (cap_req && full && !pop) overflow <= 1'b1;
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    logic [TRACE_TS_W-1:0] ts_cnt;

    // Free-running; clear deliberately leaves the time base alone.
    always_ff @(posedge clk) begin
        if (reset) ts_cnt <= '0;
        else       ts_cnt <= ts_cnt + TRACE_TS_W'(1);
    end

    assign fifo_wdata = {ts_cnt, result_i};
    assign rd_data    = rd_valid ? fifo_rdata[DATA_W-1:0] : '0;
    assign rd_ts      = rd_valid ? fifo_rdata[ENTRY_W-1:DATA_W] : '0;
`else
    assign fifo_wdata = result_i;
    assign rd_data    = rd_valid ? fifo_rdata : '0;
`endif

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (clear),
        .push  (push),
        .pop   (pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .count (count)
    );

endmodule

// File: tb/tb_result_trace_buffer.sv
// Directed bench for result_trace_buffer; covers timestamps when TRACE_TIMESTAMP_EN is defined.
module tb_result_trace_buffer;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 16;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [DATA_W-1:0]      result_i;
    logic                   capture_en;
    logic                   clear;
    logic                   rd_valid;
    logic                   rd_ready;
    logic [DATA_W-1:0]      rd_data;
    logic [$clog2(DEPTH):0] count;
    logic                   overflow;
`ifdef TRACE_TIMESTAMP_EN
    logic [15:0]            rd_ts;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    result_trace_buffer #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .result_i   (result_i),
        .capture_en (capture_en),
        .clear      (clear),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .count      (count),
        .overflow   (overflow)
`ifdef TRACE_TIMESTAMP_EN
        ,
        .rd_ts      (rd_ts)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_check(input string tag, input logic [15:0] exp);
        check_eq({tag, "_vld"}, 32'(rd_valid), 32'd1);
        check_eq(tag, 32'(rd_data), 32'(exp));
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        clear      = 1'b0;
        capture_en = 1'b0;
        rd_ready   = 1'b0;
        result_i   = '0;
        step();
        step();
        check_eq("rst_count", 32'(count), 0);
        check_eq("rst_vld", 32'(rd_valid), 0);
        check_eq("rst_data", 32'(rd_data), 0);
        check_eq("rst_ovf", 32'(overflow), 0);
        reset = 1'b0;

        // Held value captured once, change captured once more.
        capture_en = 1'b1;
        result_i   = 16'h0000;
        step();
        check_eq("first_count", 32'(count), 1);
        check_eq("first_data", 32'(rd_data), 32'h0000);
        for (int i = 0; i < 4; i++) step();
        check_eq("held_count", 32'(count), 1);
        result_i = 16'h1234;
        step();
        capture_en = 1'b0;
        check_eq("chg_count", 32'(count), 2);
        pop_check("chg_rd0", 16'h0000);
        pop_check("chg_rd1", 16'h1234);
        check_eq("chg_empty", 32'(rd_valid), 0);
        check_eq("chg_empty_data", 32'(rd_data), 0);

        // DEPTH+3 distinct values with no reader.
        capture_en = 1'b1;
        for (int i = 0; i < DEPTH + 3; i++) begin
            result_i = 16'h0100 + 16'(i);
            step();
        end
        capture_en = 1'b0;
        check_eq("ovf_count", 32'(count), DEPTH);
        check_eq("ovf_flag", 32'(overflow), 1);
        for (int i = 0; i < DEPTH; i++) pop_check("ovf_rd", 16'h0100 + 16'(i));
        check_eq("ovf_drained", 32'(rd_valid), 0);
        check_eq("ovf_sticky", 32'(overflow), 1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check_eq("clr_ovf", 32'(overflow), 0);

        // Full buffer with simultaneous capture and pop.
        capture_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            result_i = 16'h0200 + 16'(i);
            step();
        end
        check_eq("fullpp_pre", 32'(count), DEPTH);
        result_i = 16'h02FF;
        rd_ready = 1'b1;
        step();
        rd_ready   = 1'b0;
        capture_en = 1'b0;
        check_eq("fullpp_count", 32'(count), DEPTH);
        check_eq("fullpp_ovf", 32'(overflow), 0);
        check_eq("fullpp_head", 32'(rd_data), 32'h0201);
        for (int i = 1; i < DEPTH; i++) pop_check("fullpp_rd", 16'h0200 + 16'(i));
        pop_check("fullpp_last", 16'h02FF);

        // Empty with capture and rd_ready together: push only.
        capture_en = 1'b1;
        rd_ready   = 1'b1;
        result_i   = 16'h0300;
        step();
        check_eq("emptypp_count", 32'(count), 1);
        check_eq("emptypp_data", 32'(rd_data), 32'h0300);
        step();
        capture_en = 1'b0;
        rd_ready   = 1'b0;
        check_eq("emptypp_pop", 32'(count), 0);

        // Clear wins over a same-cycle capture and re-arms the tracker.
        capture_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            result_i = 16'h0400 + 16'(i);
            step();
        end
        check_eq("clr_pre", 32'(count), 3);
        clear    = 1'b1;
        result_i = 16'h0403;
        step();
        clear = 1'b0;
        check_eq("clr_count", 32'(count), 0);
        check_eq("clr_vld", 32'(rd_valid), 0);
        result_i = 16'h0402;
        step();
        capture_en = 1'b0;
        check_eq("rearm_count", 32'(count), 1);
        pop_check("rearm_rd", 16'h0402);

        // Reset mid-operation with a reader present.
        capture_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            result_i = 16'h0500 + 16'(i);
            step();
        end
        capture_en = 1'b0;
        check_eq("mrst_pre", 32'(count), 5);
        rd_ready = 1'b1;
        reset    = 1'b1;
        step();
        reset    = 1'b0;
        rd_ready = 1'b0;
        check_eq("mrst_count", 32'(count), 0);
        check_eq("mrst_vld", 32'(rd_valid), 0);
        check_eq("mrst_data", 32'(rd_data), 0);
        check_eq("mrst_ovf", 32'(overflow), 0);
        capture_en = 1'b1;
        step();
        capture_en = 1'b0;
        check_eq("mrst_unarmed", 32'(count), 1);
        pop_check("mrst_rd", 16'h0504);

`ifdef TRACE_TIMESTAMP_EN
        // Captures in cycles 3 and 10 counted from the reset edge.
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("ts_idle", 32'(rd_ts), 0);
        step();
        step();
        step();
        capture_en = 1'b1;
        result_i   = 16'h000A;
        step();
        capture_en = 1'b0;
        for (int i = 0; i < 6; i++) step();
        capture_en = 1'b1;
        result_i   = 16'h000B;
        step();
        capture_en = 1'b0;
        check_eq("ts_first", 32'(rd_ts), 32'h0003);
        pop_check("ts_data0", 16'h000A);
        check_eq("ts_second", 32'(rd_ts), 32'h000A);
        pop_check("ts_data1", 16'h000B);
        check_eq("ts_empty", 32'(rd_ts), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/result_trace_buffer.md
RESULT_TRACE_BUFFER -- requirements
Module: result_trace_buffer

Interface
REQ-001 SHALL have parameter: DEPTH, 16, number of trace entries; power of two, 4..256.
REQ-002 SHALL have parameter: DATA_W, 16, width of CPU result bus.
REQ-003 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: result_i  input  DATA_W  CPU result bus under observation.
REQ-006 SHALL have port: capture_en  input  1  enables sampling of result_i.
REQ-007 SHALL have port: clear  input  1  synchronous flush of buffer and tracker state.
REQ-008 SHALL have port: rd_valid  output  1  head entry available.
REQ-009 SHALL have port: rd_ready  input  1  consumer accepts head entry.
REQ-010 SHALL have port: rd_data  output  DATA_W  head entry value.
REQ-011 SHALL have port: count  output  $clog2(DEPTH)+1  entries held.
REQ-012 SHALL have port: overflow  output  1  sticky; set when a capture was dropped.

Function
REQ-013 SHALL capture result_i when capture_en=1 and either result_i differs from last captured value or no value captured since reset/clear.
REQ-014 SHALL update last-captured value only on an accepted push; dropped samples do not update it.
REQ-015 SHALL write a capture in the cycle it is detected; rd_valid and count reflect it from the next cycle (1-cycle latency).
REQ-016 SHALL present show-ahead data: rd_data = oldest entry while rd_valid=1; rd_data=0 while rd_valid=0.
REQ-017 SHALL pop on rd_valid & rd_ready; the next entry, or rd_valid=0, appears the following cycle.
REQ-018 SHALL, when full with no pop, drop the capture, leave contents unchanged, and set overflow.
REQ-019 SHALL, when full with a pop in the same cycle, accept both; count unchanged; no overflow.
REQ-020 SHALL, when empty, treat simultaneous capture and rd_ready as push only; no underflow, count increments.
REQ-021 SHALL wrap read/write pointers modulo DEPTH; count distinguishes full (DEPTH) from empty (0).
REQ-022 SHALL give clear priority over push and pop in the same cycle: next cycle count=0, rd_valid=0, overflow=0, tracker re-armed.

Reset
REQ-023 SHALL, on reset, set count=0, rd_valid=0, rd_data=0, overflow=0, pointers=0, tracker un-armed; storage contents need not be reset.
REQ-024 SHALL apply reset asserted mid-operation on the next edge, discarding all entries; reset priority over clear.

Configuration
REQ-025 SHALL, with TRACE_TIMESTAMP_EN defined, add output rd_ts (16 bits) and a free-running 16-bit cycle counter, 0 at reset, wrapping 0xFFFF->0x0000, not affected by clear.
REQ-026 SHALL, with TRACE_TIMESTAMP_EN defined, store the counter value with each entry and present it on rd_ts alongside rd_data (0 when rd_valid=0).
REQ-027 SHALL, without TRACE_TIMESTAMP_EN, omit rd_ts, the counter and timestamp storage; all other behaviour identical.

Structure
REQ-028 SHALL place the default DATA_W, the timestamp width (16) and the trace entry struct typedef in shared package riscpu_trace_pkg.
REQ-029 SHALL implement storage and pointers in one sub-module, trace_fifo; change detection, overflow and timestamp logic stay in the top.

Verification
REQ-030 SHALL test: reset, capture_en=1, result_i 0x0000 held 5 cycles then 0x1234 -> exactly two entries, 0x0000 then 0x1234; count=2.
REQ-031 SHALL test: rd_ready=0, DEPTH+3 distinct values -> count=DEPTH, overflow=1, readout yields the first DEPTH values in order.
REQ-032 SHALL test: full buffer, new value with rd_ready=1 in the same cycle -> count stays DEPTH, overflow=0, head advances.
REQ-033 SHALL test: 3 entries, clear and a new capture in the same cycle -> next cycle count=0, rd_valid=0; re-presenting the last value is captured again.
REQ-034 SHALL test: reset pulsed while 5 entries held and rd_ready=1 -> next cycle count=0, rd_valid=0, rd_data=0, overflow=0.
REQ-035 SHALL test: with TRACE_TIMESTAMP_EN, captures at cycles 3 and 10 after reset -> rd_ts 0x0003 then 0x000A.
